// File: rtl/sr_mon_pkg.sv
// Shared types and constants for the SR latch monitor.
//   mon_state_e : monitor FSM state encoding (visible on mon_state)
//   SR_*        : {S,R} input codes
package sr_mon_pkg;

  typedef enum logic [1:0] {
    UNKNOWN  = 2'd0,
    SETTLING = 2'd1,
    STABLE   = 2'd2,
    FORBID   = 2'd3
  } mon_state_e;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_FORB = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
//   clk : clock
//   clr : synchronous clear (highest priority)
//   inc : count enable
//   q   : count value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)                  q <= '0;
    else if (inc && q != '1)  q <= q + 1'b1;
  end

endmodule

// File: rtl/sr_latch_monitor.sv
// Cycle-accurate checker for an active-high NOR SR latch. Tracks the latch
// with a reference model, waits SETTLE_CYC cycles after every S/R change,
// then checks Q/NQ against the model and counts events.
//   clk, rst        : clock, synchronous active-high reset
//   chk_en          : enables error pulses, err_cnt and err_sticky
//   s_in, r_in      : latch stimulus (same nets driving the latch)
//   q_in, nq_in     : latch response
//   exp_q/exp_valid : model output and whether it is defined
//   mon_state       : FSM state code
//   err_*           : registered one-cycle error pulses, sticky error flag
//   *_cnt           : saturating event counters
module sr_latch_monitor
  import sr_mon_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             s_in,
  input  logic             r_in,
  input  logic             q_in,
  input  logic             nq_in,
  output logic             exp_q,
  output logic             exp_valid,
  output logic [1:0]       mon_state,
  output logic             err_forbidden,
  output logic             err_mismatch,
  output logic             err_compl,
  output logic             err_sticky,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] reset_cnt,
  output logic [CNT_W-1:0] forb_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  mon_state_e state, state_d;
  logic [3:0] settle_cnt, settle_d;
  logic [1:0] prev_sr, prev_d, sr;
  logic       exp_q_d, exp_valid_d;
  logic       forb_hit, mism_hit, compl_hit;
  logic       inc_set, inc_rst, inc_forb, err_any;

  assign sr        = {s_in, r_in};
  assign mon_state = state;
  assign err_any   = chk_en & (forb_hit | mism_hit | compl_hit);

  always_comb begin
    state_d     = state;
    settle_d    = settle_cnt;
    prev_d      = prev_sr;
    exp_q_d     = exp_q;
    exp_valid_d = exp_valid;
    forb_hit    = 1'b0;
    mism_hit    = 1'b0;
    compl_hit   = 1'b0;
    inc_set     = 1'b0;
    inc_rst     = 1'b0;
    inc_forb    = 1'b0;

    if (sr != prev_sr) begin
      // Any change (also mid-settle) restarts the settle window. The edge
      // carrying the change is never checked: the latch cannot have
      // responded to inputs it is only now seeing.
      prev_d   = sr;
      settle_d = SETTLE_LD;
      state_d  = SETTLING;
      case (sr)
        SR_SET: begin exp_q_d = 1'b1; exp_valid_d = 1'b1; inc_set = 1'b1; end
        SR_RST: begin exp_q_d = 1'b0; exp_valid_d = 1'b1; inc_rst = 1'b1; end
        SR_FORB: begin inc_forb = 1'b1; forb_hit = 1'b1; end
        default: begin
          // Releasing both inputs together is a race in a real latch.
          if (prev_sr == SR_FORB) exp_valid_d = 1'b0;
        end
      endcase
    end else begin
      case (state)
        SETTLING: begin
          if (settle_cnt <= 4'd1) begin
            settle_d = 4'd0;
            if (sr == SR_FORB)  state_d = FORBID;
            else if (exp_valid) state_d = STABLE;
            else                state_d = UNKNOWN;
          end else begin
            settle_d = settle_cnt - 4'd1;
          end
        end
        STABLE:  mism_hit  = (q_in != exp_q) | (nq_in == exp_q);
        FORBID:  mism_hit  = q_in | nq_in;   // NOR latch drives both low
        UNKNOWN: compl_hit = (q_in == nq_in);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= UNKNOWN;
      settle_cnt    <= 4'd0;
      prev_sr       <= SR_HOLD;
      exp_q         <= 1'b0;
      exp_valid     <= 1'b0;
      err_forbidden <= 1'b0;
      err_mismatch  <= 1'b0;
      err_compl     <= 1'b0;
      err_sticky    <= 1'b0;
    end else begin
      state         <= state_d;
      settle_cnt    <= settle_d;
      prev_sr       <= prev_d;
      exp_q         <= exp_q_d;
      exp_valid     <= exp_valid_d;
      err_forbidden <= chk_en & forb_hit;
      err_mismatch  <= chk_en & mism_hit;
      err_compl     <= chk_en & compl_hit;
      if (err_any) err_sticky <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_set_cnt  (.clk(clk), .clr(rst), .inc(inc_set),  .q(set_cnt));
  sat_counter #(.W(CNT_W)) u_rst_cnt  (.clk(clk), .clr(rst), .inc(inc_rst),  .q(reset_cnt));
  sat_counter #(.W(CNT_W)) u_forb_cnt (.clk(clk), .clr(rst), .inc(inc_forb), .q(forb_cnt));
  sat_counter #(.W(CNT_W)) u_err_cnt  (.clk(clk), .clr(rst), .inc(err_any),  .q(err_cnt));

endmodule

// File: tb/tb_sr_latch_monitor.sv
// Directed bench for sr_latch_monitor. A behavioural model (time since last
// input change, latch value, plain event tallies) is stepped every clock and
// compared against two DUTs (CNT_W=8 and CNT_W=2); literal checks pin it.
module tb_sr_latch_monitor;

  localparam int SC = 2;

  logic clk = 1'b0;
  logic rst, chk_en, s_in, r_in, q_in, nq_in;

  logic       exp_q, exp_valid, err_forbidden, err_mismatch, err_compl, err_sticky;
  logic [1:0] mon_state;
  logic [7:0] set_cnt, reset_cnt, forb_cnt, err_cnt;
  logic       b_exp_q, b_exp_valid, b_ef, b_em, b_ec, b_es;
  logic [1:0] b_state;
  logic [1:0] b_set, b_rst, b_forb, b_err;

  sr_latch_monitor #(.SETTLE_CYC(SC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .chk_en(chk_en), .s_in(s_in), .r_in(r_in),
    .q_in(q_in), .nq_in(nq_in), .exp_q(exp_q), .exp_valid(exp_valid),
    .mon_state(mon_state), .err_forbidden(err_forbidden),
    .err_mismatch(err_mismatch), .err_compl(err_compl), .err_sticky(err_sticky),
    .set_cnt(set_cnt), .reset_cnt(reset_cnt), .forb_cnt(forb_cnt), .err_cnt(err_cnt));

  sr_latch_monitor #(.SETTLE_CYC(SC), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .chk_en(chk_en), .s_in(s_in), .r_in(r_in),
    .q_in(q_in), .nq_in(nq_in), .exp_q(b_exp_q), .exp_valid(b_exp_valid),
    .mon_state(b_state), .err_forbidden(b_ef),
    .err_mismatch(b_em), .err_compl(b_ec), .err_sticky(b_es),
    .set_cnt(b_set), .reset_cnt(b_rst), .forb_cnt(b_forb), .err_cnt(b_err));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0] m_sr;
  int  m_age, m_set, m_rst, m_forb, m_err;
  bit  m_q, m_valid, m_sticky, m_pf, m_pm, m_pc;

  function automatic int sat(input int v, input int w);
    int top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  // State follows from how long the inputs have been steady and what they are.
  function automatic int m_state();
    if (m_age < SC)          return 1;
    if (m_sr == 2'b11)       return 3;
    if (m_valid)             return 2;
    return 0;
  endfunction

  task automatic model_step();
    logic [1:0] sr;
    int st;
    bit chg;
    if (rst) begin
      m_sr = 2'b00; m_age = SC; m_q = 0; m_valid = 0; m_sticky = 0;
      m_set = 0; m_rst = 0; m_forb = 0; m_err = 0;
      m_pf = 0; m_pm = 0; m_pc = 0;
      return;
    end
    sr  = {s_in, r_in};
    st  = m_state();
    chg = (sr != m_sr);
    m_pf = chk_en && chg && sr == 2'b11;
    m_pm = chk_en && !chg && ((st == 2 && (q_in != m_q || nq_in != !m_q)) ||
                              (st == 3 && (q_in || nq_in)));
    m_pc = chk_en && !chg && st == 0 && q_in == nq_in;
    if (m_pf || m_pm || m_pc) begin m_err++; m_sticky = 1; end
    if (chg) begin
      if (sr == 2'b10)      begin m_q = 1; m_valid = 1; m_set++; end
      else if (sr == 2'b01) begin m_q = 0; m_valid = 1; m_rst++; end
      else if (sr == 2'b11) m_forb++;
      else if (m_sr == 2'b11) m_valid = 0;
      m_sr  = sr;
      m_age = 0;
    end else if (m_age < 1000) begin
      m_age++;
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("mon_state", mon_state, m_state());
    chk("exp_q", exp_q, m_q);
    chk("exp_valid", exp_valid, m_valid);
    chk("err_forbidden", err_forbidden, m_pf);
    chk("err_mismatch", err_mismatch, m_pm);
    chk("err_compl", err_compl, m_pc);
    chk("err_sticky", err_sticky, m_sticky);
    chk("set_cnt", set_cnt, sat(m_set, 8));
    chk("reset_cnt", reset_cnt, sat(m_rst, 8));
    chk("forb_cnt", forb_cnt, sat(m_forb, 8));
    chk("err_cnt", err_cnt, sat(m_err, 8));
    chk("w2_set_cnt", b_set, sat(m_set, 2));
    chk("w2_reset_cnt", b_rst, sat(m_rst, 2));
    chk("w2_forb_cnt", b_forb, sat(m_forb, 2));
    chk("w2_err_cnt", b_err, sat(m_err, 2));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit s, input bit r, input bit q, input bit nq, input int n);
    s_in = s; r_in = r; q_in = q; nq_in = nq;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; chk_en = 1;
    drive(0, 0, 0, 1, 2);
    rst = 0;
    drive(0, 0, 0, 1, 2);
    chk("L_reset_state", mon_state, 0);
    chk("L_reset_valid", exp_valid, 0);
    chk("L_reset_sticky", err_sticky, 0);

    // Set: SETTLING for two edges, STABLE two cycles after the change edge.
    drive(1, 0, 1, 0, 2);
    chk("L_set_settling", mon_state, 1);
    drive(1, 0, 1, 0, 1);
    chk("L_set_stable", mon_state, 2);
    drive(1, 0, 1, 0, 7);
    chk("L_set_expq", exp_q, 1);
    chk("L_set_cnt", set_cnt, 1);

    drive(0, 0, 1, 0, 10);
    chk("L_hold_expq", exp_q, 1);
    drive(0, 1, 0, 1, 10);
    chk("L_rst_expq", exp_q, 0);
    drive(0, 0, 0, 1, 10);
    chk("L_seq_expq", exp_q, 0);
    chk("L_seq_set", set_cnt, 1);
    chk("L_seq_rst", reset_cnt, 1);
    chk("L_seq_err", err_cnt, 0);

    // Forbidden input, then simultaneous release.
    drive(1, 1, 0, 0, 10);
    chk("L_forb_state", mon_state, 3);
    chk("L_forb_cnt", forb_cnt, 1);
    chk("L_forb_err", err_cnt, 1);
    drive(0, 0, 0, 1, 5);
    chk("L_race_state", mon_state, 0);
    chk("L_race_valid", exp_valid, 0);
    drive(0, 0, 1, 1, 3);
    chk("L_compl_pulse", err_compl, 1);
    chk("L_compl_err", err_cnt, 4);

    // Wrong Q in STABLE, with and without checking.
    drive(1, 0, 1, 0, 5);
    drive(1, 0, 0, 0, 3);
    chk("L_mism_pulse", err_mismatch, 1);
    drive(1, 0, 1, 0, 2);
    chk("L_mism_err", err_cnt, 7);
    chk("L_mism_sticky", err_sticky, 1);
    chk_en = 0;
    drive(1, 0, 0, 0, 3);
    chk("L_off_pulse", err_mismatch, 0);
    chk("L_off_err", err_cnt, 7);
    drive(1, 0, 1, 0, 2);
    chk_en = 1;

    // Toggle every cycle with wrong outputs: never leaves SETTLING.
    for (int i = 0; i < 6; i++) begin
      drive(i % 2 == 0 ? 1'b0 : 1'b1, i % 2 == 0 ? 1'b1 : 1'b0, 0, 0, 1);
      chk("L_toggle_state", mon_state, 1);
    end
    drive(1, 0, 1, 0, 5);
    chk("L_toggle_err", err_cnt, 7);

    // Saturation on the 2-bit instance.
    rst = 1;
    drive(0, 0, 0, 1, 2);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 0, 3);
      drive(0, 1, 0, 1, 3);
    end
    chk("L_w2_set_sat", b_set, 3);
    chk("L_w2_rst_sat", b_rst, 3);
    chk("L_w8_set", set_cnt, 5);

    // Reset in the middle of a settle window.
    drive(1, 0, 1, 0, 1);
    chk("L_mid_settling", mon_state, 1);
    rst = 1;
    drive(1, 0, 1, 0, 1);
    chk("L_mid_state", mon_state, 0);
    chk("L_mid_set", set_cnt, 0);
    chk("L_mid_expq", exp_q, 0);
    rst = 0;
    drive(0, 0, 0, 1, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_latch_monitor.md
Name: sr_latch_monitor

Overview:
- Synchronous checker that observes the stimulus (S, R) and the response (Q, NQ) of an active-high NOR-style SR latch lab block.
- Keeps a cycle-accurate reference model of the latch and flags forbidden inputs, wrong outputs and non-complementary outputs.
- Counts set, reset, forbidden and error events so a lab board or bench can score a latch under test without waveform inspection.
- Sits beside the latch under test and reads the same S/R nets that drive it.

Parameters:
- SETTLE_CYC, 2, cycles allowed after any S/R change before outputs are checked; legal range 1..15.
- CNT_W, 8, width of every event counter.

Ports:
- clk  input  1  system clock; all sampling is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- chk_en  input  1  enables error reporting and error counting.
- s_in  input  1  latch S input, already synchronous to clk.
- r_in  input  1  latch R input, already synchronous to clk.
- q_in  input  1  latch Q output.
- nq_in  input  1  latch NQ output.
- exp_q  output  1  model's expected Q.
- exp_valid  output  1  model state is defined; low after reset and after 11->00.
- mon_state  output  2  current FSM state code.
- err_forbidden  output  1  one-cycle pulse on entry to S=R=1.
- err_mismatch  output  1  one-cycle pulse: outputs differ from the model.
- err_compl  output  1  one-cycle pulse: Q==NQ while the model is undefined.
- err_sticky  output  1  set by any error pulse; cleared only by rst.
- set_cnt  output  CNT_W  entries into SR=10.
- reset_cnt  output  CNT_W  entries into SR=01.
- forb_cnt  output  CNT_W  entries into SR=11.
- err_cnt  output  CNT_W  cycles with any error pulse.

Behaviour:
- Reset values (rst=1 at an edge):
  - state UNKNOWN; exp_q=0; exp_valid=0.
  - prev_sr=00; settle counter 0.
  - All counters, pulses and err_sticky cleared.
  - rst mid-settle or mid-forbidden discards everything.
- States: UNKNOWN=0, SETTLING=1, STABLE=2, FORBID=3.
- Input change (sr != prev_sr, evaluated every cycle regardless of chk_en):
  - Load settle counter with SETTLE_CYC; go to SETTLING; prev_sr <= sr.
  - Model update:
    - 10: exp_q=1, valid=1; set_cnt++.
    - 01: exp_q=0, valid=1; reset_cnt++.
    - 11: forb_cnt++; err_forbidden pulse, reported only if chk_en=1.
    - 00 from 11: valid=0 (race; result undefined).
    - 00 otherwise: hold.
  - A change during SETTLING restarts the count.
- SETTLING: decrement each cycle. When the count reaches 0, the next state is:
  - FORBID if sr=11;
  - else STABLE if valid;
  - else UNKNOWN.
  - No output checks are made during SETTLING.
- STABLE: require q_in==exp_q and nq_in==~exp_q; otherwise err_mismatch.
- FORBID: require q_in=0 and nq_in=0 (NOR behaviour); otherwise err_mismatch.
- UNKNOWN: require q_in != nq_in; otherwise err_compl.
- Latency:
  - Error pulses are registered and appear the cycle after the offending sample.
  - Counters update on the same edge as the pulse.
- chk_en=0: the model, the FSM and the set/reset/forb counters still track. All error pulses are held at 0; err_cnt and err_sticky do not change.
- Counters saturate at 2^CNT_W-1; they never wrap.
- Multiple error pulses in one cycle: err_cnt increments by 1 only.

Decomposition:
- Package sr_mon_pkg holds:
  - the state enum (UNKNOWN, SETTLING, STABLE, FORBID);
  - SR code constants SR_HOLD=00, SR_RST=01, SR_SET=10, SR_FORB=11.
- One sub-module, sat_counter (parameter W; ports inc, clr, q). It is instantiated four times.

Test Plan:
- rst, then SR=10 held 10 cycles with Q=1, NQ=0 -> exp_q=1, state reaches STABLE 2 cycles after the change, set_cnt=1, no errors.
- 10 -> 00 -> 01 -> 00, each held 10 cycles with correct latch outputs -> exp_q sequence 1,1,0,0; set_cnt=1, reset_cnt=1, err_cnt=0.
- SR=11 for 10 cycles with Q=NQ=0, then 00 -> err_forbidden pulses once, forb_cnt=1, FORBID then UNKNOWN, exp_valid=0. Q=NQ=1 held in UNKNOWN -> err_compl pulses each cycle.
- STABLE with exp_q=1 while Q is forced to 0 for 3 cycles -> 3 err_mismatch pulses, err_cnt=3, err_sticky=1. Repeat with chk_en=0 -> no pulses and err_cnt unchanged.
- SR toggled every cycle for 6 cycles with SETTLE_CYC=2 -> state stays SETTLING, no mismatch reported despite wrong Q.
- CNT_W=2, 5 set/reset pairs -> set_cnt=3 (saturated). rst asserted mid-SETTLING -> all outputs return to reset values on the next edge.
